// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.
// Hits return one cycle after the lookup; misses issue a single word fetch and fill the line.
module inst_cache #(
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned ADDR_HI     = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        branch_flag_in,
  input  logic        if_req_in,
  input  logic [31:0] inst_addr_in,
  output logic        inst_done_out,
  output logic [31:0] inst_out,
  output logic        mc_req_out,
  output logic [31:0] mc_addr_out,
  input  logic [31:0] mc_inst_in,
  input  logic        mc_done_in
);

  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_W = ADDR_HI - INDEX_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    ABORT
  } state_t;

  state_t                   state;
  logic [LINES-1:0]         valid;
  logic [TAG_W-1:0]         tag_arr  [LINES];
  logic [31:0]              data_arr [LINES];

  logic [INDEX_WIDTH-1:0]   req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     req_io;
  logic                     hit;
  logic [INDEX_WIDTH-1:0]   fill_idx;
  logic [TAG_W-1:0]         fill_tag;
  logic                     fill_io;
  logic                     fill_en;
  logic                     unused_addr_bits;

  always_comb begin
    req_idx  = inst_addr_in[INDEX_WIDTH+1:2];
    req_tag  = inst_addr_in[ADDR_HI:2+INDEX_WIDTH];
    req_io   = (inst_addr_in[17:16] == 2'b11);
    hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag) && !req_io;
    // The fill address is the held miss address, not the (possibly changed) IF address.
    fill_idx = mc_addr_out[INDEX_WIDTH+1:2];
    fill_tag = mc_addr_out[ADDR_HI:2+INDEX_WIDTH];
    fill_io  = (mc_addr_out[17:16] == 2'b11);
    fill_en  = rdy_in && !rst_in && (state != IDLE) && mc_done_in && !fill_io;
  end

  assign unused_addr_bits = ^{inst_addr_in[31:ADDR_HI+1], inst_addr_in[1:0],
                              mc_addr_out[31:ADDR_HI+1], mc_addr_out[1:0]};

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mc_inst_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      valid         <= '0;
      inst_done_out <= 1'b0;
      inst_out      <= '0;
      mc_req_out    <= 1'b0;
      mc_addr_out   <= '0;
    end else if (rdy_in) begin
      inst_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!inst_done_out && if_req_in && !branch_flag_in) begin
            if (hit) begin
              inst_done_out <= 1'b1;
              inst_out      <= data_arr[req_idx];
            end else begin
              mc_req_out  <= 1'b1;
              mc_addr_out <= inst_addr_in;
              state       <= MISS;
            end
          end
        end
        MISS: begin
          if (mc_done_in) begin
            if (!fill_io) valid[fill_idx] <= 1'b1;
            mc_req_out <= 1'b0;
            state      <= IDLE;
            if (!branch_flag_in) begin
              inst_done_out <= 1'b1;
              inst_out      <= mc_inst_in;
            end
          end else if (branch_flag_in) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          if (mc_done_in) begin
            if (!fill_io) valid[fill_idx] <= 1'b1;
            mc_req_out <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios followed by randomized fetches,
// compared against a transaction-level model of the cache contents.
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        branch_flag_in;
  logic        if_req_in;
  logic [31:0] inst_addr_in;
  logic        inst_done_out;
  logic [31:0] inst_out;
  logic        mc_req_out;
  logic [31:0] mc_addr_out;
  logic [31:0] mc_inst_in;
  logic        mc_done_in;

  inst_cache #(.INDEX_WIDTH(7), .ADDR_HI(17)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .branch_flag_in (branch_flag_in),
    .if_req_in      (if_req_in),
    .inst_addr_in   (inst_addr_in),
    .inst_done_out  (inst_done_out),
    .inst_out       (inst_out),
    .mc_req_out     (mc_req_out),
    .mc_addr_out    (mc_addr_out),
    .mc_inst_in     (mc_inst_in),
    .mc_done_in     (mc_done_in)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit          m_valid [128];
  int unsigned m_tag   [128];
  logic [31:0] m_data  [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return ((a >> 16) & 32'h3) == 32'h3;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  // flush_at/stall_at: wait-cycle index at which to pulse branch / freeze rdy for 3 cycles; -1 = never.
  // flush_at == lat puts the branch in the same cycle as mc_done_in.
  task automatic fetch(input logic [31:0] a, input int lat, input int flush_at, input int stall_at);
    int unsigned idx;
    int unsigned tg;
    bit          io;
    bit          hit;
    bit          aborted;
    logic [31:0] held_out;
    idx     = (a >> 2) % 128;
    tg      = (a >> 9) % 512;
    io      = is_io(a);
    hit     = !io && m_valid[idx] && (m_tag[idx] == tg);
    aborted = 1'b0;

    if_req_in    = 1'b1;
    inst_addr_in = a;
    tick();
    if (hit) begin
      check("hit_done", {31'b0, inst_done_out}, 32'd1);
      check("hit_data", inst_out, m_data[idx]);
      check("hit_noreq", {31'b0, mc_req_out}, 32'd0);
      tick();
      check("hit_pulse", {31'b0, inst_done_out}, 32'd0);
      check("hit_noreissue", {31'b0, mc_req_out}, 32'd0);
      if_req_in = 1'b0;
      return;
    end

    check("miss_req", {31'b0, mc_req_out}, 32'd1);
    check("miss_addr", mc_addr_out, a);
    check("miss_nodone", {31'b0, inst_done_out}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      if (i == stall_at) begin
        held_out = inst_out;
        rdy_in   = 1'b0;
        repeat (3) begin
          tick();
          check("stall_req", {31'b0, mc_req_out}, 32'd1);
          check("stall_addr", mc_addr_out, a);
          check("stall_done", {31'b0, inst_done_out}, 32'd0);
          check("stall_out", inst_out, held_out);
        end
        rdy_in = 1'b1;
      end
      if (i == flush_at) begin
        branch_flag_in = 1'b1;
        if_req_in      = 1'b0;
        aborted        = 1'b1;
      end
      tick();
      branch_flag_in = 1'b0;
      check("wait_req", {31'b0, mc_req_out}, 32'd1);
      check("wait_addr", mc_addr_out, a);
      check("wait_nodone", {31'b0, inst_done_out}, 32'd0);
    end

    if (flush_at == lat) begin
      branch_flag_in = 1'b1;
      if_req_in      = 1'b0;
      aborted        = 1'b1;
    end
    mc_done_in = 1'b1;
    mc_inst_in = mem_word(a);
    tick();
    mc_done_in     = 1'b0;
    branch_flag_in = 1'b0;
    mc_inst_in     = $urandom;
    check("fin_req", {31'b0, mc_req_out}, 32'd0);
    if (!io) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = mem_word(a);
    end
    if (aborted) begin
      check("abort_nodone", {31'b0, inst_done_out}, 32'd0);
    end else begin
      check("fin_done", {31'b0, inst_done_out}, 32'd1);
      check("fin_data", inst_out, mem_word(a));
    end
    tick();
    check("fin_pulse", {31'b0, inst_done_out}, 32'd0);
    check("fin_idle", {31'b0, mc_req_out}, 32'd0);
    if_req_in = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          lat;
    int          fl;
    int          st;

    rst_in         = 1'b1;
    rdy_in         = 1'b1;
    branch_flag_in = 1'b0;
    if_req_in      = 1'b0;
    inst_addr_in   = '0;
    mc_inst_in     = '0;
    mc_done_in     = 1'b0;
    tick();
    tick();
    check("rst_done", {31'b0, inst_done_out}, 32'd0);
    check("rst_out", inst_out, 32'd0);
    check("rst_req", {31'b0, mc_req_out}, 32'd0);
    check("rst_addr", mc_addr_out, 32'd0);
    rst_in = 1'b0;
    clear_model();

    fetch(32'h4, 4, -1, -1);         // cold miss
    fetch(32'h4, 0, -1, -1);         // hit
    fetch(32'h204, 3, -1, -1);       // conflict evicts 0x4
    fetch(32'h4, 2, -1, -1);         // conflict back
    fetch(32'h8, 5, 2, -1);          // flush mid-miss
    fetch(32'h8, 0, -1, -1);         // line filled by aborted fetch
    fetch(32'hC, 3, 3, -1);          // flush together with mc_done
    fetch(32'hC, 0, -1, -1);
    fetch(32'h10, 4, -1, 1);         // rdy stall mid-miss
    fetch(32'h30000, 2, -1, -1);     // I/O bypass
    fetch(32'h30000, 1, -1, -1);

    // Request coinciding with a branch must do nothing, even on a would-be hit.
    if_req_in      = 1'b1;
    branch_flag_in = 1'b1;
    inst_addr_in   = 32'h10;
    tick();
    check("brreq_done", {31'b0, inst_done_out}, 32'd0);
    check("brreq_req", {31'b0, mc_req_out}, 32'd0);
    branch_flag_in = 1'b0;
    if_req_in      = 1'b0;
    tick();

    // Reset in the middle of a miss, then the previously filled 0x4 must miss again.
    fetch(32'h4, 0, -1, -1);
    if_req_in    = 1'b1;
    inst_addr_in = 32'h14;
    tick();
    check("prerst_req", {31'b0, mc_req_out}, 32'd1);
    rst_in    = 1'b1;
    if_req_in = 1'b0;
    tick();
    check("midrst_done", {31'b0, inst_done_out}, 32'd0);
    check("midrst_out", inst_out, 32'd0);
    check("midrst_req", {31'b0, mc_req_out}, 32'd0);
    check("midrst_addr", mc_addr_out, 32'd0);
    rst_in = 1'b0;
    clear_model();
    fetch(32'h4, 3, -1, -1);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h30000 | ($urandom_range(0, 7) << 2);
        1:       a = ($urandom << 18) | ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2);
        default: a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2);
      endcase
      lat = $urandom_range(1, 6);
      fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat) : -1;
      st  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
      fetch(a, lat, fl, st);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
